// File: rtl/ams_slow_adc_monitor.sv
// Per-channel slow-ADC monitor: latest sample, windowed average, min/max, hi/lo threshold alarms, level irq.
// Latency: sample effects visible 1 cycle after the strobe; irq 1 cycle after alarm_sts; bus read data/ack 1 cycle.
// Backpressure: none; every strobe and every bus request is accepted in its cycle.
//
// Ports: clk_i/rst_i (sync, active high); smp_vld_i/smp_ch_i/smp_dat_i sample strobe;
//        sys_* simple register bus (addr[11:0] decoded, err tied 0); irq_o = |(alarm_sts & alarm_msk), registered.
// Optional: define AMS_MON_HYST_EN to require 2 consecutive out-of-range samples before an alarm bit sets.
module ams_slow_adc_monitor #(
    parameter int NCH      = 8,
    parameter int DW       = 12,
    parameter int AVG_LOG2 = 4,
    parameter int CHW      = 6
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           smp_vld_i,
    input  logic [CHW-1:0] smp_ch_i,
    input  logic [DW-1:0]  smp_dat_i,
    output logic           irq_o,
    input  logic [31:0]    sys_addr_i,
    input  logic [31:0]    sys_wdata_i,
    input  logic           sys_wen_i,
    input  logic           sys_ren_i,
    output logic [31:0]    sys_rdata_o,
    output logic           sys_err_o,
    output logic           sys_ack_o
);
    localparam int AW       = 2 * NCH;
    localparam int ACCW     = DW + AVG_LOG2;
    localparam int CNTW     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int WIN_LAST = (1 << AVG_LOG2) - 1;

    logic [DW-1:0]   latest [NCH];
    logic [DW-1:0]   avg    [NCH];
    logic [DW-1:0]   min_v  [NCH];
    logic [DW-1:0]   max_v  [NCH];
    logic [DW-1:0]   thr_hi [NCH];
    logic [DW-1:0]   thr_lo [NCH];
    logic [ACCW-1:0] acc    [NCH];
    logic [CNTW-1:0] cnt    [NCH];
    logic [NCH-1:0]  avg_vld;
    logic [AW-1:0]   alarm_sts;
    logic [AW-1:0]   alarm_msk;

    // Bus decode
    logic [11:0]    addr;
    logic           ch_space;
    logic [5:0]     addr_ch;
    logic [1:0]     addr_reg;
    logic           wr_sts, wr_msk, clr_stats;
    logic [AW+31:0] wdat_ext;
    logic [AW-1:0]  wmask;

    assign addr      = sys_addr_i[11:0];
    assign ch_space  = (addr[11:10] == 2'b00);
    assign addr_ch   = addr[9:4];
    assign addr_reg  = addr[3:2];
    assign wr_sts    = sys_wen_i && (addr == 12'h400);
    assign wr_msk    = sys_wen_i && (addr == 12'h404);
    assign clr_stats = sys_wen_i && (addr == 12'h408) && sys_wdata_i[0];
    // Zero-extend so the mask slice is legal for any NCH (only the low 32 alarm bits are bus-visible).
    assign wdat_ext  = {{AW{1'b0}}, sys_wdata_i};
    assign wmask     = wdat_ext[AW-1:0];

    // Per-channel combinational terms. Channel indices >= NCH never match, so such samples are dropped.
    logic [NCH-1:0]  smp_hit, over_hi, under_lo, thr_wr;
    logic [ACCW-1:0] acc_sum [NCH];
    logic [DW-1:0]   avg_new [NCH];

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            smp_hit[c]  = smp_vld_i && (smp_ch_i == CHW'(c));
            over_hi[c]  = smp_dat_i > thr_hi[c];
            under_lo[c] = smp_dat_i < thr_lo[c];
            thr_wr[c]   = sys_wen_i && ch_space && (addr_ch == 6'(c)) && (addr_reg == 2'd3);
            acc_sum[c]  = acc[c] + ACCW'(smp_dat_i);
            avg_new[c]  = DW'(acc_sum[c] >> AVG_LOG2);
        end
    end

    logic [AW-1:0] alarm_set;

`ifdef AMS_MON_HYST_EN
    // One pending flag per direction: an alarm needs the previous sample of that channel out of range too.
    logic [NCH-1:0] pend_hi, pend_lo;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_stats) begin
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (smp_hit[c]) begin
                    pend_hi[c] <= over_hi[c];
                    pend_lo[c] <= under_lo[c];
                end
            end
        end
    end

    always_comb begin
        alarm_set = '0;
        for (int c = 0; c < NCH; c++) begin
            alarm_set[2*c]   = smp_hit[c] && over_hi[c] && pend_hi[c];
            alarm_set[2*c+1] = smp_hit[c] && under_lo[c] && pend_lo[c];
        end
    end
`else
    always_comb begin
        alarm_set = '0;
        for (int c = 0; c < NCH; c++) begin
            alarm_set[2*c]   = smp_hit[c] && over_hi[c];
            alarm_set[2*c+1] = smp_hit[c] && under_lo[c];
        end
    end
`endif

    // Channel state, alarms and irq. Threshold compare uses pre-write thresholds; clear beats sample stats.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NCH; c++) begin
                latest[c] <= '0;
                avg[c]    <= '0;
                min_v[c]  <= '1;
                max_v[c]  <= '0;
                thr_hi[c] <= '1;
                thr_lo[c] <= '0;
                acc[c]    <= '0;
                cnt[c]    <= '0;
            end
            avg_vld   <= '0;
            alarm_sts <= '0;
            alarm_msk <= '0;
            irq_o     <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (smp_hit[c]) begin
                    latest[c] <= smp_dat_i;
                end
                if (thr_wr[c]) begin
                    thr_hi[c] <= sys_wdata_i[DW-1+16:16];
                    thr_lo[c] <= sys_wdata_i[DW-1:0];
                end
                if (clr_stats) begin
                    acc[c]     <= '0;
                    cnt[c]     <= '0;
                    avg_vld[c] <= 1'b0;
                    min_v[c]   <= '1;
                    max_v[c]   <= '0;
                end else if (smp_hit[c]) begin
                    if (smp_dat_i < min_v[c]) min_v[c] <= smp_dat_i;
                    if (smp_dat_i > max_v[c]) max_v[c] <= smp_dat_i;
                    if (cnt[c] == CNTW'(WIN_LAST)) begin
                        avg[c]     <= avg_new[c];
                        avg_vld[c] <= 1'b1;
                        acc[c]     <= '0;
                        cnt[c]     <= '0;
                    end else begin
                        acc[c] <= acc_sum[c];
                        cnt[c] <= cnt[c] + CNTW'(1);
                    end
                end
            end
            // Set after clear so a new alarm in the same cycle as its W1C survives.
            alarm_sts <= (alarm_sts & ~(wr_sts ? wmask : '0)) | alarm_set;
            if (wr_msk) alarm_msk <= wmask;
            irq_o <= |(alarm_sts & alarm_msk);
        end
    end

    // Read mux (unmapped addresses return 0)
    logic [31:0]    rd_val;
    logic [AW+31:0] sts_ext, msk_ext;

    assign sts_ext = {32'b0, alarm_sts};
    assign msk_ext = {32'b0, alarm_msk};

    always_comb begin
        rd_val = '0;
        if (ch_space) begin
            for (int c = 0; c < NCH; c++) begin
                if (addr_ch == 6'(c)) begin
                    case (addr_reg)
                        2'd0:    rd_val = 32'(latest[c]);
                        2'd1:    rd_val = {avg_vld[c], 31'b0} | 32'(avg[c]);
                        2'd2:    rd_val = (32'(max_v[c]) << 16) | 32'(min_v[c]);
                        default: rd_val = (32'(thr_hi[c]) << 16) | 32'(thr_lo[c]);
                    endcase
                end
            end
        end else begin
            case (addr)
                12'h400: rd_val = sts_ext[31:0];
                12'h404: rd_val = msk_ext[31:0];
                12'h40C: rd_val = {8'(NCH), 8'(DW), 8'(AVG_LOG2), 8'h01};
                default: rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sys_rdata_o <= '0;
            sys_ack_o   <= 1'b0;
        end else begin
            sys_rdata_o <= sys_ren_i ? rd_val : '0;
            sys_ack_o   <= sys_wen_i | sys_ren_i;
        end
    end

    assign sys_err_o = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{sys_addr_i[31:12], addr[1:0], sys_wdata_i,
                           sts_ext[AW+31:32], msk_ext[AW+31:32], wdat_ext[AW+31:AW]};

endmodule
